// File: rtl/mips_regfile_write_arbiter.sv
// Shares the register-file write port between ALU and load writeback through one-entry buffers.
// A grant in cycle N writes in cycle N+1; ready = buffer empty or granted, never dependent on valid.
module mips_regfile_write_arbiter #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 5,
  parameter int STARVE_MAX = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              alu_req_valid,
  output logic              alu_req_ready,
  input  logic [ADDR_W-1:0] alu_req_reg,
  input  logic [DATA_W-1:0] alu_req_data,
  input  logic              mem_req_valid,
  output logic              mem_req_ready,
  input  logic [ADDR_W-1:0] mem_req_reg,
  input  logic [DATA_W-1:0] mem_req_data,
  output logic              signal_reg_write,
  output logic [ADDR_W-1:0] write_reg,
  output logic [DATA_W-1:0] write_data,
  output logic              grant_src,
  output logic [31:0]       pending_mask
);

  typedef struct packed {
    logic [ADDR_W-1:0] rg;
    logic [DATA_W-1:0] dat;
  } entry_t;

  localparam int              CNT_W      = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

  entry_t           alu_buf;
  entry_t           mem_buf;
  logic             alu_full;
  logic             mem_full;
  logic             alu_older;
  logic [CNT_W-1:0] starve_cnt;

  logic gnt_alu;
  logic gnt_mem;
  logic alu_acc;
  logic mem_acc;
  logic alu_load;
  logic mem_load;
  logic alu_keep;

  // Fixed priority to memory, except same-register ordering and the starvation guard.
  always_comb begin
    gnt_alu = 1'b0;
    gnt_mem = 1'b0;
    if (alu_full && mem_full) begin
      if (alu_buf.rg == mem_buf.rg) begin
        gnt_alu = alu_older;
      end else begin
        gnt_alu = (starve_cnt == STARVE_LIM);
      end
      gnt_mem = !gnt_alu;
    end else begin
      gnt_alu = alu_full;
      gnt_mem = mem_full;
    end
  end

  assign alu_req_ready = !alu_full || gnt_alu;
  assign mem_req_ready = !mem_full || gnt_mem;

  assign alu_acc  = alu_req_valid && alu_req_ready;
  assign mem_acc  = mem_req_valid && mem_req_ready;
  // Writes to $zero are consumed without occupying the buffer.
  assign alu_load = alu_acc && (alu_req_reg != '0);
  assign mem_load = mem_acc && (mem_req_reg != '0);
  assign alu_keep = alu_full && !gnt_alu;

  always_comb begin
    pending_mask = '0;
    if (alu_full) pending_mask[alu_buf.rg] = 1'b1;
    if (mem_full) pending_mask[mem_buf.rg] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_full <= 1'b0;
      alu_buf  <= '0;
    end else if (alu_load) begin
      alu_full <= 1'b1;
      alu_buf  <= '{rg: alu_req_reg, dat: alu_req_data};
    end else if (alu_acc || gnt_alu) begin
      alu_full <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_full <= 1'b0;
      mem_buf  <= '0;
    end else if (mem_load) begin
      mem_full <= 1'b1;
      mem_buf  <= '{rg: mem_req_reg, dat: mem_req_data};
    end else if (mem_acc || gnt_mem) begin
      mem_full <= 1'b0;
    end
  end

  // ALU is older only if its entry survives this edge while memory loads a new one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_older  <= 1'b0;
      starve_cnt <= '0;
    end else begin
      alu_older <= alu_keep && (alu_older || mem_load);
      if (!alu_full || gnt_alu) begin
        starve_cnt <= '0;
      end else if (gnt_mem && (starve_cnt != STARVE_LIM)) begin
        starve_cnt <= starve_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      signal_reg_write <= 1'b0;
      write_reg        <= '0;
      write_data       <= '0;
      grant_src        <= 1'b0;
    end else begin
      signal_reg_write <= gnt_alu || gnt_mem;
      if (gnt_alu) begin
        write_reg  <= alu_buf.rg;
        write_data <= alu_buf.dat;
        grant_src  <= 1'b0;
      end else if (gnt_mem) begin
        write_reg  <= mem_buf.rg;
        write_data <= mem_buf.dat;
        grant_src  <= 1'b1;
      end
    end
  end

endmodule
